data_pipe_arb_m2s: RTL and testbench

//  N-slaver to 1-master valid/ready data pipe with built-in arbitration.
//  - Successor to the software-switched M2S interconnect; selects its own grant (fixed priority or round-robin).
//  - Optionally locks the grant for a whole packet (until the last beat).
//  - Output is a registered 2-entry skid stage: full throughput, no combinational ready path upstream.
//  - Sits between stream producers (DMA/parsers) and a shared downstream consumer.

---
 rtl/data_pipe_arb_m2s_if.sv | 26 ++
 rtl/data_pipe_arb_m2s.sv | 140 ++++++++++++++
 tb/tb_data_pipe_arb_m2s.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_pipe_arb_m2s_if.sv
// rtl/data_pipe_arb_m2s_if.sv - stream bundle between N producers, the arbiter and one consumer
interface data_pipe_arb_m2s_if #(
  parameter int NUM   = 8,
  parameter int DSIZE = 32
);
  logic [NUM-1:0]       s_valid;
  logic [NUM*DSIZE-1:0] s_data;
  logic [NUM-1:0]       s_last;
  logic [NUM-1:0]       s_ready;
  logic                 m_valid;
  logic [DSIZE-1:0]     m_data;
  logic                 m_last;
  logic                 m_ready;

  // arbiter side: consumes the slave streams, produces the master stream
  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  // environment side: producers and the downstream consumer
  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/data_pipe_arb_m2s.sv
// rtl/data_pipe_arb_m2s.sv - N-to-1 valid/ready pipe with packet-locking arbitration and 2-entry skid output
module data_pipe_arb_m2s #(
  parameter int NUM      = 8,
  parameter int DSIZE    = 32,
  parameter int ARB_MODE = 1,
  parameter int LOCK_PKT = 1,
  parameter int NSIZE    = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 clk_en,
  data_pipe_arb_m2s_if.master  bus,
  output logic [NSIZE-1:0]     curr_path,
  output logic                 path_vld
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [NSIZE-1:0] ptr, ptr_nxt, path_nxt, win, sel;
  logic             vld_nxt, win_found, any_req;
  int               sum;

  logic             out_vld, skid_vld;
  logic [DSIZE-1:0] out_data, skid_data;
  logic             out_last, skid_last;

  logic [DSIZE-1:0] in_data;
  logic             in_valid, in_last;
  logic             accept, drain, release_pkt;

  assign any_req  = |bus.s_valid;
  assign in_valid = bus.s_valid[curr_path];
  assign in_last  = bus.s_last[curr_path];
  assign in_data  = bus.s_data[curr_path*DSIZE +: DSIZE];

  // ready comes only from registers, so there is no combinational path from m_ready upstream
  assign bus.s_ready = (state == GRANT && !skid_vld) ? (NUM'(1) << curr_path) : '0;

  assign accept      = clk_en && (state == GRANT) && !skid_vld && in_valid;
  assign drain       = clk_en && out_vld && bus.m_ready;
  assign release_pkt = accept && ((LOCK_PKT == 0) || in_last);

  assign bus.m_valid = out_vld;
  assign bus.m_data  = out_data;
  assign bus.m_last  = out_last;

  // winner search: lowest index, or first requester at/after the round-robin pointer
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    sum       = 0;
    sel       = '0;
    for (int i = 0; i < NUM; i++) begin
      sum = (ARB_MODE != 0) ? (int'(ptr) + i) : i;
      sel = NSIZE'((sum >= NUM) ? (sum - NUM) : sum);
      if (!win_found && bus.s_valid[sel]) begin
        win       = sel;
        win_found = 1'b1;
      end
    end
  end

  // next grant state: take a winner from IDLE, or hand over directly on packet release
  always_comb begin
    state_nxt = state;
    path_nxt  = curr_path;
    vld_nxt   = path_vld;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clk_en && any_req) begin
          state_nxt = GRANT;
          path_nxt  = win;
          vld_nxt   = 1'b1;
          ptr_nxt   = (win == NSIZE'(NUM - 1)) ? '0 : win + 1'b1;
        end
      end
      GRANT: begin
        if (release_pkt) begin
          if (any_req) begin
            path_nxt = win;
            ptr_nxt  = (win == NSIZE'(NUM - 1)) ? '0 : win + 1'b1;
          end else begin
            state_nxt = IDLE;
            vld_nxt   = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grant registers; clk_en low freezes them
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= IDLE;
      curr_path <= '0;
      path_vld  <= 1'b0;
      ptr       <= '0;
    end else if (clk_en) begin
      state     <= state_nxt;
      curr_path <= path_nxt;
      path_vld  <= vld_nxt;
      ptr       <= ptr_nxt;
    end
  end

  // output register plus skid register; the skid entry only fills while the output is stalled
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else if (clk_en) begin
      if (drain || !out_vld) begin
        if (skid_vld) begin
          out_vld  <= 1'b1;
          out_data <= skid_data;
          out_last <= skid_last;
          skid_vld <= 1'b0;
        end else if (accept) begin
          out_vld  <= 1'b1;
          out_data <= in_data;
          out_last <= in_last;
        end else begin
          out_vld  <= 1'b0;
        end
      end else if (accept) begin
        skid_vld  <= 1'b1;
        skid_data <= in_data;
        skid_last <= in_last;
      end
    end
  end

endmodule

// File: tb/tb_data_pipe_arb_m2s.sv
// tb/tb_data_pipe_arb_m2s.sv - bench for the arbitrated M2S pipe
module tb_data_pipe_arb_m2s;
  localparam int NUM   = 4;
  localparam int DSIZE = 16;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic [1:0] curr_path;
  logic       path_vld;

  always #5 clock = ~clock;

  data_pipe_arb_m2s_if #(.NUM(NUM), .DSIZE(DSIZE)) bus ();

  data_pipe_arb_m2s #(.NUM(NUM), .DSIZE(DSIZE), .ARB_MODE(1), .LOCK_PKT(1)) dut (
    .clock(clock), .rst_n(rst_n), .clk_en(clk_en), .bus(bus),
    .curr_path(curr_path), .path_vld(path_vld)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  sv;
    logic        mr;
    logic        ce;
    logic [3:0]  rdy;
    logic        mv;
    logic [15:0] md;
    logic [1:0]  path;
    logic        pv;
  } vec_t;

  vec_t tbl[18];

  // reference model: per-slave producer queues and expected queues of {last, data}
  // data = {source[1:0], sequence[13:0]}
  logic [16:0] prod_q[NUM][$];
  logic [16:0] exp_q[NUM][$];
  int          seq[NUM];
  logic [3:0]  cur_valid;
  bit          in_pkt;
  int          lock_src;
  int          src_log[$];
  int          acc_cnt, del_cnt;
  bit          prev_hold;
  logic [16:0] prev_m;

  task automatic clear_model();
    for (int k = 0; k < NUM; k++) begin
      prod_q[k].delete();
      exp_q[k].delete();
    end
    cur_valid = '0;
    in_pkt    = 1'b0;
    lock_src  = 0;
    src_log.delete();
    acc_cnt   = 0;
    del_cnt   = 0;
    prev_hold = 1'b0;
  endtask

  task automatic push_pkt(input int k, input int len);
    logic [16:0] w;
    for (int b = 0; b < len; b++) begin
      w = {(b == len - 1), 2'(k), 14'(seq[k])};
      seq[k]++;
      prod_q[k].push_back(w);
      exp_q[k].push_back(w);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    clear_model();
    bus.s_valid = '0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic run_cycle(input int vprob, input int rprob, input int eprob);
    logic [16:0] w;
    logic [3:0]  fire;
    logic        mf;
    int          src;
    @(negedge clock);
    for (int k = 0; k < NUM; k++) begin
      if (prod_q[k].size() == 0) cur_valid[k] = 1'b0;
      else if (!cur_valid[k]) cur_valid[k] = (int'($urandom_range(99)) < vprob);
      w = (prod_q[k].size() != 0) ? prod_q[k][0] : 17'h0;
      bus.s_data[k*DSIZE +: DSIZE] = w[15:0];
      bus.s_last[k] = w[16];
    end
    bus.s_valid = cur_valid;
    bus.m_ready = (int'($urandom_range(99)) < rprob);
    clk_en      = (int'($urandom_range(99)) < eprob);
    #1;
    chk("ready_onehot0", 32'($onehot0(bus.s_ready)), 32'd1);
    if (prev_hold)
      chk("hold_stable", 32'({bus.m_valid, bus.m_last, bus.m_data}), 32'({1'b1, prev_m}));
    fire = bus.s_valid & bus.s_ready & {NUM{clk_en}};
    for (int k = 0; k < NUM; k++) begin
      if (fire[k]) begin
        void'(prod_q[k].pop_front());
        cur_valid[k] = 1'b0;
        acc_cnt++;
      end
    end
    mf = bus.m_valid & bus.m_ready & clk_en;
    if (mf) begin
      src = int'(bus.m_data[15:14]);
      del_cnt++;
      if (in_pkt) chk("pkt_lock", 32'(src), 32'(lock_src));
      if (exp_q[src].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h expected=none", bus.m_data);
      end else begin
        w = exp_q[src].pop_front();
        chk("beat", 32'({bus.m_last, bus.m_data}), 32'(w));
      end
      in_pkt   = !bus.m_last;
      lock_src = src;
      src_log.push_back(src);
    end
    chk("inflight_le2", 32'(acc_cnt - del_cnt <= 2), 32'd1);
    prev_hold = bus.m_valid && !mf;
    prev_m    = {bus.m_last, bus.m_data};
  endtask

  initial begin
    int exp_order[6];
    int cyc;
    bit done;

    tbl[0]  = '{4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 16'h0000, 2'd0, 1'b0};
    tbl[1]  = '{4'hF, 1'b1, 1'b1, 4'h1, 1'b0, 16'h0000, 2'd0, 1'b1};
    tbl[2]  = '{4'hF, 1'b1, 1'b1, 4'h2, 1'b1, 16'hD000, 2'd1, 1'b1};
    tbl[3]  = '{4'hF, 1'b1, 1'b1, 4'h4, 1'b1, 16'hD001, 2'd2, 1'b1};
    tbl[4]  = '{4'hF, 1'b1, 1'b1, 4'h8, 1'b1, 16'hD002, 2'd3, 1'b1};
    tbl[5]  = '{4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 16'hD003, 2'd0, 1'b1};
    tbl[6]  = '{4'hF, 1'b0, 1'b1, 4'h2, 1'b1, 16'hD000, 2'd1, 1'b1};
    tbl[7]  = '{4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 16'hD000, 2'd2, 1'b1};
    tbl[8]  = '{4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 16'hD000, 2'd2, 1'b1};
    tbl[9]  = '{4'hF, 1'b1, 1'b1, 4'h0, 1'b1, 16'hD000, 2'd2, 1'b1};
    tbl[10] = '{4'hF, 1'b1, 1'b1, 4'h4, 1'b1, 16'hD001, 2'd2, 1'b1};
    tbl[11] = '{4'hF, 1'b1, 1'b0, 4'h8, 1'b1, 16'hD002, 2'd3, 1'b1};
    tbl[12] = '{4'hF, 1'b1, 1'b0, 4'h8, 1'b1, 16'hD002, 2'd3, 1'b1};
    tbl[13] = '{4'hF, 1'b1, 1'b0, 4'h8, 1'b1, 16'hD002, 2'd3, 1'b1};
    tbl[14] = '{4'hF, 1'b1, 1'b0, 4'h8, 1'b1, 16'hD002, 2'd3, 1'b1};
    tbl[15] = '{4'hF, 1'b1, 1'b0, 4'h8, 1'b1, 16'hD002, 2'd3, 1'b1};
    tbl[16] = '{4'hF, 1'b1, 1'b1, 4'h8, 1'b1, 16'hD002, 2'd3, 1'b1};
    tbl[17] = '{4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 16'hD003, 2'd0, 1'b1};

    for (int k = 0; k < NUM; k++) seq[k] = 0;
    clear_model();

    // reset held with every slave requesting
    bus.s_valid = '1;
    bus.s_last  = '1;
    bus.m_ready = 1'b1;
    for (int k = 0; k < NUM; k++) bus.s_data[k*DSIZE +: DSIZE] = 16'(16'hD000 + k);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      chk($sformatf("rst%0d_s_ready", c), 32'(bus.s_ready), 32'd0);
      chk($sformatf("rst%0d_m_valid", c), 32'(bus.m_valid), 32'd0);
      chk($sformatf("rst%0d_path_vld", c), 32'(path_vld), 32'd0);
    end

    // round-robin streaming, backpressure into the skid entry, clk_en freeze
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      if (i == 0) rst_n = 1'b1;
      bus.s_valid = tbl[i].sv;
      bus.m_ready = tbl[i].mr;
      clk_en      = tbl[i].ce;
      #1;
      chk($sformatf("vec%0d_s_ready", i), 32'(bus.s_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_m_valid", i), 32'(bus.m_valid), 32'(tbl[i].mv));
      chk($sformatf("vec%0d_m_data", i), 32'(bus.m_data), 32'(tbl[i].md));
      chk($sformatf("vec%0d_curr_path", i), 32'(curr_path), 32'(tbl[i].path));
      chk($sformatf("vec%0d_path_vld", i), 32'(path_vld), 32'(tbl[i].pv));
      if (tbl[i].mv) chk($sformatf("vec%0d_m_last", i), 32'(bus.m_last), 32'd1);
    end
    clk_en = 1'b1;

    // packet lock: slave 0 raised mid-packet does not preempt slave 1
    do_reset();
    push_pkt(1, 4);
    push_pkt(3, 1);
    for (int c = 0; c < 12; c++) begin
      if (c == 2) push_pkt(0, 1);
      run_cycle(100, 100, 100);
    end
    exp_order = '{1, 1, 1, 1, 3, 0};
    chk("lock_beats", 32'(src_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < src_log.size()) chk($sformatf("lock_order%0d", i), 32'(src_log[i]), 32'(exp_order[i]));

    // reset mid-packet: buffered beats and pointer discarded
    do_reset();
    push_pkt(2, 4);
    for (int c = 0; c < 3; c++) run_cycle(100, 100, 100);
    do_reset();
    #1;
    chk("post_rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("post_rst_path_vld", 32'(path_vld), 32'd0);
    for (int k = 0; k < NUM; k++) push_pkt(k, 1);
    for (int c = 0; c < 10; c++) run_cycle(100, 100, 100);
    chk("post_rst_beats", 32'(src_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < src_log.size()) chk($sformatf("post_rst_order%0d", i), 32'(src_log[i]), 32'(i));

    // randomized traffic against the queue model
    do_reset();
    for (int k = 0; k < NUM; k++)
      for (int p = 0; p < 6; p++) push_pkt(k, 1 + int'($urandom_range(3)));
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 3000) begin
      run_cycle(70, 60, 90);
      cyc++;
      done = 1'b1;
      for (int k = 0; k < NUM; k++)
        if (exp_q[k].size() != 0 || prod_q[k].size() != 0) done = 1'b0;
    end
    for (int k = 0; k < NUM; k++)
      chk($sformatf("rand_left_slave%0d", k), 32'(exp_q[k].size()), 32'd0);
    chk("rand_count", 32'(del_cnt), 32'(acc_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
